melody_player: RTL and testbench

Parametrised melody sequencer for the buzzer output. It plays a song from a writable note memory; each entry carries a pitch index and a duration. Features: run-time start/stop, optional looping, a silent articulation gap between notes, and a done pulse. It drives the speaker pin directly and supersedes the fixed-song, fixed-duration player.

---
 rtl/music_pkg.sv | 18 +
 rtl/tone_gen.sv | 43 ++++
 rtl/melody_player.sv | 166 ++++++++++++++++
 tb/tb_melody_player.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the melody sequencer: FSM states, note-word layout
// and the half-period table (12 MHz clocks per half cycle of each pitch).
package music_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StPlay, StGap} state_e;

  localparam int unsigned PitchMsb = 7;
  localparam int unsigned PitchLsb = 4;
  localparam int unsigned DurMsb   = 3;
  localparam int unsigned DurLsb   = 0;

  // Entry 0 is a rest; 9..15 are one octave above 2..8.
  localparam logic [15:0] PITCH_HALF [16] = '{
    16'd0,     16'd22989, 16'd20478, 16'd18237, 16'd17192, 16'd15306, 16'd13636, 16'd12876,
    16'd11472, 16'd10239, 16'd9118,  16'd8596,  16'd7653,  16'd6818,  16'd6438,  16'd5736
  };

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles its registered output every half_period clocks
// while enabled; restart clears the phase and forces the output low.
module tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [15:0] half_period,
  input  logic        enable,
  output logic        wave
);

  logic [15:0] cnt_q, cnt_d;
  logic        wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (restart) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (enable) begin
      if (cnt_q == half_period - 16'd1) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: plays pitch/duration entries from a writable note RAM onto
// the speaker pin with a silent gap after each note, optional looping and done.
module melody_player
  import music_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned TICK_DIV  = 750000,
  parameter int unsigned GAP_CLKS  = 120000,
  parameter int unsigned DIV_SHIFT = 0,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W:0]   song_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              speaker_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  // One timer serves both the tick divider in PLAY and the gap count in GAP.
  localparam int unsigned     TmrMax   = (TICK_DIV > GAP_CLKS) ? TICK_DIV : GAP_CLKS;
  localparam int unsigned     TmrW     = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] TickLast = TmrW'(TICK_DIV - 1);
  localparam logic [TmrW-1:0] GapLast  = TmrW'(GAP_CLKS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] note_idx_q, note_idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [3:0]        dur_q, dur_d;
  logic              done_q, done_d;
  logic [7:0]        rd_q, rd_d;
  logic [7:0]        mem_q [DEPTH];

  logic [3:0]  note_pitch, note_dur;
  logic [15:0] half_raw, half_period;
  logic        accept, play_end, gap_end, last_note, restart, tone_en;

  assign note_pitch  = rd_q[PitchMsb:PitchLsb];
  assign note_dur    = rd_q[DurMsb:DurLsb];
  assign half_raw    = PITCH_HALF[note_pitch] >> DIV_SHIFT;
  assign half_period = (half_raw == '0) ? 16'd1 : half_raw;
  assign accept      = start && !stop && (song_len != '0);
  assign play_end    = (tmr_q == TickLast) && (dur_q == note_dur);
  assign gap_end     = (tmr_q == GapLast);
  assign last_note   = ({1'b0, note_idx_q} + (ADDR_W + 1)'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (accept) state_d = StFetch;
        StFetch: state_d = StPlay;
        StPlay:  if (play_end) state_d = StGap;
        StGap:   if (gap_end) state_d = (!last_note || loop) ? StFetch : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    tone_en = (state_q == StPlay) && (note_pitch != 4'd0);
    // Clearing on the last PLAY cycle as well guarantees a low pin through GAP.
    restart = (state_q != StPlay) || (state_d != StPlay);
  end

  always_comb begin
    note_idx_d = note_idx_q;
    len_d      = len_q;
    tmr_d      = tmr_q;
    dur_d      = dur_q;
    done_d     = 1'b0;
    rd_d       = (state_q == StFetch) ? mem_q[note_idx_q] : rd_q;
    if (stop) begin
      note_idx_d = '0;
      tmr_d      = '0;
      dur_d      = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            len_d      = song_len;
            note_idx_d = '0;
          end
        end
        StFetch: begin
          tmr_d = '0;
          dur_d = '0;
        end
        StPlay: begin
          if (tmr_q == TickLast) begin
            tmr_d = '0;
            dur_d = play_end ? 4'd0 : dur_q + 4'd1;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        StGap: begin
          if (gap_end) begin
            tmr_d = '0;
            if (!last_note) begin
              note_idx_d = note_idx_q + ADDR_W'(1);
            end else begin
              note_idx_d = '0;
              done_d     = !loop;
            end
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_idx_q <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      dur_q      <= '0;
      done_q     <= 1'b0;
      rd_q       <= '0;
    end else begin
      note_idx_q <= note_idx_d;
      len_q      <= len_d;
      tmr_q      <= tmr_d;
      dur_q      <= dur_d;
      done_q     <= done_d;
      rd_q       <= rd_d;
    end
  end

  // Read-before-write: a same-cycle write and fetch of one address returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  tone_gen u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .half_period (half_period),
    .enable      (tone_en),
    .wave        (speaker_out)
  );

  assign done     = done_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player: a timeline model queues every expected
// output change (cycle, value); a negedge monitor pops and compares each change.
module tb_melody_player;

  localparam int unsigned Depth   = 32;
  localparam int unsigned AddrW   = 5;
  localparam int          TickDiv = 4;
  localparam int          GapClks = 2;
  localparam int          KSpk    = 0;
  localparam int          KDone   = 1;
  localparam int          KIdx    = 2;
  localparam int          KBusy   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop = 1'b0;
  logic [AddrW:0]   song_len = '0;
  logic             wr_en = 1'b0;
  logic [AddrW-1:0] wr_addr = '0;
  logic [7:0]       wr_data = '0;
  logic             speaker_out, busy, done;
  logic [AddrW-1:0] note_idx;

  melody_player #(
    .DEPTH     (Depth),
    .TICK_DIV  (TickDiv),
    .GAP_CLKS  (GapClks),
    .DIV_SHIFT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .song_len    (song_len),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .speaker_out (speaker_out),
    .busy        (busy),
    .done        (done),
    .note_idx    (note_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q [$];
  logic [7:0]  shadow [Depth];
  int          exp_idx = 0;
  int          exp_spk = 0;
  bit          mon_en = 1'b0;
  logic        p_spk, p_done, p_busy;
  logic [AddrW-1:0] p_idx;
  int          f, fin, s, dummy;
  int          pitch_half [16] = '{0, 22989, 20478, 18237, 17192, 15306, 13636, 12876,
                                   11472, 10239, 9118, 8596, 7653, 6818, 6438, 5736};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event word: kind in [63:56], cycle in [55:24], value in [23:0].
  function automatic logic [63:0] ev(input int kind, input int c, input int v);
    return {8'(kind), 32'(c), 24'(v)};
  endfunction

  task automatic push(input int kind, input int c, input int v);
    exp_q.push_back(ev(kind, c, v));
  endtask

  task automatic got(input int kind, input int v);
    logic [63:0] obs;
    obs = ev(kind, cyc, v);
    if (exp_q.size() == 0) check_eq("unexpected_event", obs, '1);
    else check_eq($sformatf("event_kind%0d", kind), obs, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (speaker_out !== p_spk) got(KSpk, int'(speaker_out));
      if (done !== p_done) got(KDone, int'(done));
      if (note_idx !== p_idx) got(KIdx, int'(note_idx));
      if (busy !== p_busy) got(KBusy, int'(busy));
      p_spk  = speaker_out;
      p_done = done;
      p_idx  = note_idx;
      p_busy = busy;
    end
  end

  // Entry fetched at cycle fc: PLAY from fc+1 for (dur+1)*TickDiv, then the gap.
  task automatic model_entry(input int i, input int fc, output int nf);
    int p, d, len, h;
    if (i != exp_idx) begin
      push(KIdx, fc, i);
      exp_idx = i;
    end
    p   = int'(shadow[i][7:4]);
    d   = int'(shadow[i][3:0]);
    len = (d + 1) * TickDiv;
    if (p != 0) begin
      h = pitch_half[p] >> 8;
      if (h == 0) h = 1;
      for (int t = h; t < len; t += h) begin
        exp_spk = 1 - exp_spk;
        push(KSpk, fc + 1 + t, exp_spk);
      end
    end
    if (exp_spk != 0) begin
      exp_spk = 0;
      push(KSpk, fc + 1 + len, 0);
    end
    nf = fc + 1 + len + GapClks;
  endtask

  task automatic model_song(input int fc, input int n, input int passes, output int last_c);
    int cur;
    cur = fc;
    push(KBusy, fc, 1);
    for (int ps = 0; ps < passes; ps++) begin
      for (int i = 0; i < n; i++) model_entry(i, cur, cur);
    end
    push(KDone, cur, 1);
    if (exp_idx != 0) push(KIdx, cur, 0);
    exp_idx = 0;
    push(KBusy, cur, 0);
    push(KDone, cur + 1, 0);
    last_c = cur + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic write_note(input int a, input int pitch, input int dur);
    wr_en     = 1'b1;
    wr_addr   = AddrW'(a);
    wr_data   = {4'(pitch), 4'(dur)};
    shadow[a] = {4'(pitch), 4'(dur)};
    step();
    wr_en = 1'b0;
  endtask

  task automatic start_song(input int n, output int fc);
    song_len = (AddrW + 1)'(n);
    start    = 1'b1;
    fc       = cyc + 1;
    step();
    start = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check_eq("rst_speaker", speaker_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_note_idx", note_idx, 0);
    p_spk = 1'b0; p_done = 1'b0; p_idx = '0; p_busy = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // Two short notes, no audible toggle; done 18 clocks after FETCH entry.
    write_note(0, 1, 0);
    write_note(1, 2, 1);
    start_song(2, f);
    model_song(f, 2, 1, fin);
    wait_until(fin + 3);
    check_eq("a_pending", exp_q.size(), 0);

    // Long C5 then long C6; a start while busy must be ignored.
    write_note(0, 8, 15);
    write_note(1, 15, 15);
    start_song(2, f);
    model_song(f, 2, 1, fin);
    wait_until(f + 30);
    start_song(1, dummy);
    wait_until(fin + 3);
    check_eq("b_pending", exp_q.size(), 0);

    // Rest: pin stays low, busy high throughout.
    write_note(0, 0, 3);
    start_song(1, f);
    model_song(f, 1, 1, fin);
    wait_until(fin + 3);
    check_eq("c_pending", exp_q.size(), 0);

    // Looping three-entry song; loop dropped during the third entry of pass two.
    write_note(0, 1, 0);
    write_note(1, 2, 1);
    write_note(2, 3, 0);
    loop = 1'b1;
    start_song(3, f);
    model_song(f, 3, 2, fin);
    wait_until(f + 45);
    loop = 1'b0;
    wait_until(fin + 3);
    check_eq("d_pending", exp_q.size(), 0);

    // Stop together with start while the pin is high.
    write_note(0, 8, 15);
    start_song(1, f);
    push(KBusy, f, 1);
    push(KSpk, f + 45, 1);
    wait_until(f + 50);
    start = 1'b1;
    stop  = 1'b1;
    s = cyc + 1;
    push(KSpk, s, 0);
    push(KBusy, s, 0);
    step();
    start = 1'b0;
    stop  = 1'b0;
    wait_until(s + 80);
    check_eq("e_pending", exp_q.size(), 0);

    // Asynchronous reset in the gap of note 1, then a zero-length start.
    write_note(0, 1, 0);
    write_note(1, 2, 1);
    start_song(2, f);
    push(KBusy, f, 1);
    push(KIdx, f + 7, 1);
    wait_until(f + 16);
    rst_n = 1'b0;
    push(KIdx, f + 16, 0);
    push(KBusy, f + 16, 0);
    exp_idx = 0;
    step();
    check_eq("f_rst_speaker", speaker_out, 0);
    check_eq("f_rst_busy", busy, 0);
    check_eq("f_rst_done", done, 0);
    check_eq("f_rst_note_idx", note_idx, 0);
    step();
    rst_n = 1'b1;
    step();
    start_song(0, dummy);
    repeat (10) step();
    check_eq("f_zero_len_busy", busy, 0);
    check_eq("f_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
